// File: rtl/siso_lane_reader_if.sv
// Handshake-free bus between the SISO lane outputs / Johnson8 decoder and the lane reader.
interface siso_lane_reader_if #(
   parameter int unsigned ERR_W = 8
);
   logic [7:0]       phase;
   logic [3:0]       lane;
   logic             check_en;
   logic             ref_bit;
   logic             clr_err;
   logic             d_out;
   logic             d_stb;
   logic             locked;
   logic             phase_err;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output phase, lane, check_en, ref_bit, clr_err,
      input  d_out, d_stb, locked, phase_err, err_cnt
   );

   modport slave (
      input  phase, lane, check_en, ref_bit, clr_err,
      output d_out, d_stb, locked, phase_err, err_cnt
   );
endinterface

// File: rtl/siso_lane_reader.sv
// Read side of the 4-lane latch SISO: tracks the Johnson8 phase, deserialises the lanes
// into one bit stream (lane0..3 per frame) and counts mismatches against a reference bit.
module siso_lane_reader #(
   parameter int unsigned SAMPLE_OFS  = 1,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned ERR_W       = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   siso_lane_reader_if.slave bus
);

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned PH_W      = 8;

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_ACQUIRE  = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   localparam logic [3:0]       LAST_FRAME = 4'(LOCK_FRAMES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;
   localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

   logic [1:0]           state_q, state_d;
   logic [3:0]           frame_cnt_q, frame_cnt_d;
   logic [PH_W-1:0]      phase_q;
   logic                 d_out_q, d_out_d;
   logic                 d_stb_q, d_stb_d;
   logic                 phase_err_q, phase_err_d;
   logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;

   logic [PH_W-1:0]      phase_next;
   logic                 phase_onehot;
   logic                 phase_ok;
   logic [NUM_LANES-1:0] lane_sel;
   logic                 sample_en;
   logic                 sample_bit;
   logic                 mismatch;

   // Sequence continuity is only enforced once tracking has started.
   assign phase_next   = {phase_q[PH_W-2:0], phase_q[PH_W-1]};
   assign phase_onehot = $onehot(bus.phase);
   assign phase_ok     = phase_onehot &&
                         ((state_q == ST_UNLOCKED) || (bus.phase == phase_next));

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      localparam int unsigned SEL = (2 * k + SAMPLE_OFS) % PH_W;
      assign lane_sel[k] = bus.phase[SEL];
   end

   assign sample_en  = (state_q == ST_LOCKED) && phase_ok && (|lane_sel);
   assign sample_bit = |(lane_sel & bus.lane);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      phase_err_d = 1'b0;
      case (state_q)
         ST_UNLOCKED: begin
            if (bus.phase == 8'h01) begin
               state_d     = ST_ACQUIRE;
               frame_cnt_d = 4'd0;
            end
         end
         ST_ACQUIRE: begin
            if (!phase_ok) begin
               state_d     = ST_UNLOCKED;
               phase_err_d = 1'b1;
            end else if (bus.phase[PH_W-1]) begin
               frame_cnt_d = frame_cnt_q + 4'd1;
               if (frame_cnt_q == LAST_FRAME) begin
                  state_d = ST_LOCKED;
               end
            end
         end
         ST_LOCKED: begin
            if (!phase_ok) begin
               state_d     = ST_UNLOCKED;
               phase_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_UNLOCKED;
         end
      endcase
   end

   always_comb begin
      d_stb_d = sample_en;
      d_out_d = d_out_q;
      if (sample_en) begin
         d_out_d = sample_bit;
      end
   end

   // The checker looks at the strobe currently on the outputs, so REF_BIT is aligned to D_STB.
   assign mismatch = d_stb_q && bus.check_en && (d_out_q != bus.ref_bit);

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bus.clr_err) begin
         err_cnt_d = '0;
      end else if (mismatch && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_UNLOCKED;
         frame_cnt_q <= 4'd0;
         phase_q     <= '0;
         d_out_q     <= 1'b0;
         d_stb_q     <= 1'b0;
         phase_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= bus.phase;
         d_out_q     <= d_out_d;
         d_stb_q     <= d_stb_d;
         phase_err_q <= phase_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.d_out     = d_out_q;
   assign bus.d_stb     = d_stb_q;
   assign bus.locked    = (state_q == ST_LOCKED);
   assign bus.phase_err = phase_err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_siso_lane_reader.sv
// Directed bench for siso_lane_reader: behavioural phase/lock model plus a strobe scoreboard.
module tb_siso_lane_reader;

   localparam int ERR_W = 8;
   localparam int OFS   = 1;
   localparam int LOCKN = 2;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   siso_lane_reader_if #(.ERR_W(ERR_W)) bus ();

   siso_lane_reader #(
      .SAMPLE_OFS (OFS),
      .LOCK_FRAMES(LOCKN),
      .ERR_W      (ERR_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   // model state: 0 unlocked, 1 acquire, 2 locked
   int               m_st;
   int               m_frames;
   logic [7:0]       m_prev;
   logic             m_dout;
   logic             m_stb;
   logic             m_perr;
   logic [ERR_W-1:0] m_err;

   bit               exp_q[$];
   bit               ref_q[$];
   int               n_vec;
   int               n_bad;
   int               pidx;
   int               stb_seen;
   logic [3:0]       cap;
   logic             dstb_prev;
   logic             ref_inv;
   logic             loopback;
   logic [7:0]       lfsr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [7:0] v);
      idx_of = -1;
      for (int i = 0; i < 8; i++) if (v[i]) idx_of = i;
   endfunction

   // One clock: drive inputs, predict the registered outputs, clock, compare.
   task automatic cyc(input logic [7:0] ph);
      logic             valid;
      int               idx, rel, n_st, n_frames;
      logic             n_dout, n_stb, n_perr;
      logic [ERR_W-1:0] n_err;
      bus.phase = ph;
      if (loopback && m_stb && ref_q.size() > 0) bus.ref_bit = ref_q.pop_front();
      else bus.ref_bit = m_dout ^ ref_inv;
      if (loopback && ph[0]) begin bus.lane[0] = lfsr[7]; ref_q.push_back(lfsr[7]); end
      if (loopback && ph[2]) begin bus.lane[1] = lfsr[7]; ref_q.push_back(lfsr[7]); end
      if (loopback && ph[4]) begin bus.lane[2] = lfsr[7]; ref_q.push_back(lfsr[7]); end
      if (loopback && ph[6]) begin bus.lane[3] = lfsr[7]; ref_q.push_back(lfsr[7]); end
      if (loopback && (ph[0] | ph[2] | ph[4] | ph[6]))
         lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      idx      = idx_of(ph);
      valid    = $onehot(ph) && (m_st == 0 || idx == (idx_of(m_prev) + 1) % 8);
      n_st     = m_st;
      n_frames = m_frames;
      n_dout   = m_dout;
      n_stb    = 1'b0;
      n_perr   = 1'b0;
      n_err    = m_err;
      if (bus.clr_err) n_err = '0;
      else if (bus.check_en && m_stb && (m_dout != bus.ref_bit) && m_err != {ERR_W{1'b1}})
         n_err = m_err + 1'b1;
      if (m_st != 0 && !valid) begin
         n_perr = 1'b1;
         n_st   = 0;
      end else if (m_st == 0) begin
         if (ph == 8'h01) begin n_st = 1; n_frames = 0; end
      end else if (m_st == 1) begin
         if (ph[7]) begin
            n_frames++;
            if (n_frames == LOCKN) n_st = 2;
         end
      end else begin
         rel = (idx - OFS + 8) % 8;
         if (rel % 2 == 0) begin
            n_stb  = 1'b1;
            n_dout = bus.lane[rel/2];
         end
      end
      if (rst) begin
         n_st = 0; n_frames = 0; n_dout = 1'b0; n_stb = 1'b0; n_perr = 1'b0; n_err = '0;
      end
      if (n_stb) exp_q.push_back(n_dout);

      @(posedge clk);
      #1;
      m_st     = n_st;
      m_frames = n_frames;
      m_prev   = rst ? 8'h00 : ph;
      m_dout   = n_dout;
      m_stb    = n_stb;
      m_perr   = n_perr;
      m_err    = n_err;

      chk("d_stb", {31'd0, bus.d_stb}, {31'd0, m_stb});
      chk("locked", {31'd0, bus.locked}, {31'd0, m_st == 2});
      chk("phase_err", {31'd0, bus.phase_err}, {31'd0, m_perr});
      chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
      chk("stb_gap", {31'd0, dstb_prev & bus.d_stb}, 32'd0);
      if (bus.d_stb === 1'b1) begin
         stb_seen++;
         cap = {bus.d_out, cap[3:1]};
         if (exp_q.size() == 0) chk("spurious_stb", {31'd0, bus.d_stb}, 32'd0);
         else chk("d_out", {31'd0, bus.d_out}, {31'd0, exp_q.pop_front()});
      end
      dstb_prev = bus.d_stb;
   endtask

   task automatic step();
      cyc(8'h01 << pidx);
      pidx = (pidx + 1) % 8;
   endtask

   initial begin
      n_vec = 0; n_bad = 0; pidx = 0; stb_seen = 0; cap = '0; dstb_prev = 1'b0;
      m_st = 0; m_frames = 0; m_prev = '0; m_dout = 1'b0; m_stb = 1'b0; m_perr = 1'b0;
      m_err = '0; ref_inv = 1'b0; loopback = 1'b0; lfsr = 8'h01;
      rst = 1'b1;
      bus.phase = 8'h00; bus.lane = 4'b1010; bus.check_en = 1'b0;
      bus.ref_bit = 1'b0; bus.clr_err = 1'b0;

      // reset values
      cyc(8'h00);
      cyc(8'h00);
      chk("rst_d_out", {31'd0, bus.d_out}, 32'd0);
      chk("rst_locked", {31'd0, bus.locked}, 32'd0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
      rst = 1'b0;

      // zero / multi-hot / stray phases are ignored while unlocked
      cyc(8'h00);
      cyc(8'h03);
      cyc(8'h40);
      chk("unlocked_no_perr", {31'd0, bus.phase_err}, 32'd0);

      // clean Johnson8: lock after exactly two frames, then lanes read back in order
      for (int i = 0; i < 15; i++) step();
      chk("lock_not_early", {31'd0, bus.locked}, 32'd0);
      step();
      chk("lock_rise", {31'd0, bus.locked}, 32'd1);
      cap = '0;
      for (int i = 0; i < 9; i++) step();
      chk("frame_bits", {28'd0, cap}, 32'h0000000a);

      // phase violation while locked
      step();
      step();
      cyc(8'h05);
      pidx = 4;
      chk("viol_perr", {31'd0, bus.phase_err}, 32'd1);
      chk("viol_unlock", {31'd0, bus.locked}, 32'd0);
      stb_seen = 0;
      for (int i = 0; i < 19; i++) step();
      chk("relock_not_early", {31'd0, bus.locked}, 32'd0);
      chk("no_stb_unlocked", stb_seen, 32'd0);
      step();
      chk("relock", {31'd0, bus.locked}, 32'd1);

      // every strobe mismatches: counter saturates
      bus.check_en = 1'b1;
      ref_inv = 1'b1;
      for (int i = 0; i < 76 * 8; i++) step();
      chk("err_saturate", 32'(bus.err_cnt), 32'd255);

      // clear wins over a simultaneous mismatch, then counting restarts at 1
      step();
      step();
      bus.clr_err = 1'b1;
      step();
      bus.clr_err = 1'b0;
      chk("clr_wins", 32'(bus.err_cnt), 32'd0);
      step();
      step();
      chk("count_from_1", 32'(bus.err_cnt), 32'd1);

      // reset at phase 4 while locked
      for (int i = 0; i < 7; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_locked", {31'd0, bus.locked}, 32'd0);
      chk("mid_rst_d_out", {31'd0, bus.d_out}, 32'd0);
      chk("mid_rst_err", 32'(bus.err_cnt), 32'd0);
      stb_seen = 0;
      for (int i = 0; i < 18; i++) step();
      chk("rst_relock_not_early", {31'd0, bus.locked}, 32'd0);
      chk("rst_no_stb", stb_seen, 32'd0);
      step();
      chk("rst_relock", {31'd0, bus.locked}, 32'd1);

      // loopback of an LFSR8 stream through the lanes
      ref_inv = 1'b0;
      loopback = 1'b1;
      stb_seen = 0;
      for (int i = 0; i < 1000 * 8; i++) step();
      chk("loop_err_zero", 32'(bus.err_cnt), 32'd0);
      chk("loop_strobes", stb_seen, 32'd4000);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
